// File: rtl/md_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
// The master side issues Start/Op/A/B; the slave side returns Busy/Done/HI/LO.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, Op, A, B, input Busy, Done, HI, LO);
    modport slave  (input Start, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide/MAC unit with HI/LO registers for the E stage.
// Operands are latched at Start; the result (and MAC accumulation) lands on the final count edge.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int ENABLE_MAC  = 1
) (
    input  logic      Clk,
    input  logic      Rst,
    md_unit_if.slave  bus
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_MUL  = 2'd1;
    localparam logic [1:0] CLS_DIV  = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [1:0] op_class(input logic [3:0] op);
        logic [1:0] cls;
        cls = CLS_NONE;
        if (op == OP_MULT || op == OP_MULTU) cls = CLS_MUL;
        else if (op == OP_DIV || op == OP_DIVU) cls = CLS_DIV;
        else if (op >= OP_MADD && op <= OP_MSUBU && ENABLE_MAC != 0) cls = CLS_MUL;
        return cls;
    endfunction

    // Sign/zero-extend to 2*WIDTH first so one multiplier serves both flavours.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic signed [2*WIDTH-1:0] xa;
        logic signed [2*WIDTH-1:0] xb;
        xa = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        xb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return xa * xb;
    endfunction

    // Returns {remainder, quotient}; magnitude divide then sign fix-up. The
    // most-negative / -1 case wraps naturally to quotient = A, remainder = 0.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic             neg_a;
        logic             neg_b;
        logic [WIDTH-1:0] ma;
        logic [WIDTH-1:0] mb;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        neg_a = sgn & a[WIDTH-1];
        neg_b = sgn & b[WIDTH-1];
        ma    = neg_a ? -a : a;
        mb    = neg_b ? -b : b;
        if (mb == '0) begin
            q = '0;
            r = '0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (neg_a ^ neg_b) q = -q;
        if (neg_a)         r = -r;
        return {r, q};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [1:0]         start_cls;
    logic               op_sgn;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] divr;

    assign start_cls = op_class(bus.Op);
    assign op_sgn    = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                       (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign prod      = mul_full(a_q, b_q, op_sgn);
    assign divr      = div_full(a_q, b_q, op_sgn);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (start_cls != CLS_NONE) begin
                        op_d    = bus.Op;
                        a_d     = bus.A;
                        b_d     = bus.B;
                        cnt_d   = (start_cls == CLS_MUL) ? CNT_W'(MULT_CYCLES)
                                                         : CNT_W'(DIV_CYCLES);
                        state_d = RUN;
                    end else if (bus.Op == OP_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.Op == OP_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    // MAC reads HI/LO here, at commit, not at Start.
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                        OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) {hi_d, lo_d} = divr;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Latched operands carry no reset: they are only read while in RUN.
    always_ff @(posedge Clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign bus.Busy = (state_q == RUN);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
